// File: rtl/tow_arena.sv
// rtl/tow_arena.sv - parametrised tug-of-war game core
// Synchronised buttons, LFSR-randomised arm delay, marker walk and match end detection.
module tow_arena #(
   parameter int NUM_LEDS   = 9,
   parameter int DELAY_MIN  = 16,
   parameter int DELAY_BITS = 6,
   parameter int HOLD_TICKS = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        tick,
   input  logic                        pbl,
   input  logic                        pbr,
   input  logic                        restart,
   output logic [NUM_LEDS-1:0]         led,
   output logic [$clog2(NUM_LEDS)-1:0] pos,
   output logic                        cue,
   output logic                        false_start,
   output logic                        win_l,
   output logic                        win_r
);
   localparam int PW   = $clog2(NUM_LEDS);
   localparam int DMAX = DELAY_MIN + (1 << DELAY_BITS) - 1;
   localparam int CMAX = (DMAX > HOLD_TICKS) ? DMAX : HOLD_TICKS;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [PW-1:0]       POS_C    = PW'((NUM_LEDS - 1) / 2);
   localparam logic [PW-1:0]       POS_L    = PW'(NUM_LEDS - 1);
   localparam logic [PW-1:0]       POS_1    = PW'(1);
   localparam logic [CW-1:0]       CNT_1    = CW'(1);
   localparam logic [CW-1:0]       CNT_HOLD = CW'(HOLD_TICKS);
   localparam logic [CW-1:0]       CNT_DMIN = CW'(DELAY_MIN);
   localparam logic [NUM_LEDS-1:0] LED_1    = NUM_LEDS'(1);

   localparam logic [1:0] S_ARM  = 2'd0;
   localparam logic [1:0] S_CUE  = 2'd1;
   localparam logic [1:0] S_SHOW = 2'd2;
   localparam logic [1:0] S_OVER = 2'd3;

   logic [2:0]          l_sync_q, r_sync_q;
   logic                rise_l_q, rise_r_q;
   logic [15:0]         lfsr_q;
   logic                lfsr_fb;
   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d, arm_load;
   logic [PW-1:0]       pos_q, pos_d, pos_up, pos_dn;
   logic [NUM_LEDS-1:0] led_q, led_d;
   logic                cue_q, cue_d;
   logic                fs_q, fs_d;
   logic                win_l_q, win_l_d, win_r_q, win_r_d;

   assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign arm_load = CNT_DMIN + CW'(lfsr_q[DELAY_BITS-1:0]);
   assign pos_up   = (pos_q == POS_L) ? pos_q : pos_q + POS_1;
   assign pos_dn   = (pos_q == '0) ? pos_q : pos_q - POS_1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      led_d   = led_q;
      cue_d   = cue_q;
      fs_d    = 1'b0;
      win_l_d = win_l_q;
      win_r_d = win_r_q;
      case (state_q)
         S_ARM: begin
            // A press beats an expiring tick; a double press just re-rolls the delay.
            if (rise_l_q && rise_r_q) begin
               cnt_d = arm_load;
            end else if (rise_l_q) begin
               pos_d   = pos_up;
               fs_d    = 1'b1;
               state_d = S_SHOW;
               cnt_d   = CNT_HOLD;
            end else if (rise_r_q) begin
               pos_d   = pos_dn;
               fs_d    = 1'b1;
               state_d = S_SHOW;
               cnt_d   = CNT_HOLD;
            end else if (tick) begin
               if (cnt_q == CNT_1) begin
                  state_d = S_CUE;
                  cue_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_1;
               end
            end
         end
         S_CUE: begin
            if (rise_l_q || rise_r_q) begin
               state_d = S_SHOW;
               cue_d   = 1'b0;
               cnt_d   = CNT_HOLD;
               if (rise_r_q && !rise_l_q) begin
                  pos_d = pos_up;
               end else if (rise_l_q && !rise_r_q) begin
                  pos_d = pos_dn;
               end
            end
         end
         S_SHOW: begin
            if (tick) begin
               if (cnt_q == CNT_1) begin
                  if (pos_q == POS_L) begin
                     win_r_d = 1'b1;
                     state_d = S_OVER;
                  end else if (pos_q == '0) begin
                     win_l_d = 1'b1;
                     state_d = S_OVER;
                  end else begin
                     state_d = S_ARM;
                     cnt_d   = arm_load;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_1;
               end
            end
         end
         default: begin
            if (restart) begin
               pos_d   = POS_C;
               win_l_d = 1'b0;
               win_r_d = 1'b0;
               state_d = S_ARM;
               cnt_d   = arm_load;
            end else if (tick) begin
               led_d = led_q ^ (LED_1 << pos_q);
            end
         end
      endcase
      // Lamp follows the marker everywhere except while blinking in GAMEOVER.
      if (!(state_q == S_OVER && state_d == S_OVER)) begin
         led_d = LED_1 << pos_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         l_sync_q <= '0;
         r_sync_q <= '0;
         rise_l_q <= 1'b0;
         rise_r_q <= 1'b0;
         lfsr_q   <= 16'hACE1;
         state_q  <= S_ARM;
         cnt_q    <= CNT_DMIN;
         pos_q    <= POS_C;
         led_q    <= LED_1 << POS_C;
         cue_q    <= 1'b0;
         fs_q     <= 1'b0;
         win_l_q  <= 1'b0;
         win_r_q  <= 1'b0;
      end else begin
         l_sync_q <= {l_sync_q[1:0], pbl};
         r_sync_q <= {r_sync_q[1:0], pbr};
         // Edge pulse is registered so a press lands three edges after first sampling.
         rise_l_q <= l_sync_q[1] & ~l_sync_q[2];
         rise_r_q <= r_sync_q[1] & ~r_sync_q[2];
         lfsr_q   <= {lfsr_q[14:0], lfsr_fb};
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pos_q    <= pos_d;
         led_q    <= led_d;
         cue_q    <= cue_d;
         fs_q     <= fs_d;
         win_l_q  <= win_l_d;
         win_r_q  <= win_r_d;
      end
   end

   assign led         = led_q;
   assign pos         = pos_q;
   assign cue         = cue_q;
   assign false_start = fs_q;
   assign win_l       = win_l_q;
   assign win_r       = win_r_q;

endmodule

// File: tb/tb_tow_arena.sv
// tb/tb_tow_arena.sv - scoreboard bench for tow_arena
// Round-level reference model predicts event edges; a monitor pops and compares.
module tb_tow_arena;
   localparam int N = 9, C = 4, DMIN = 16, DB = 6, HOLD = 32, TP = 3;
   localparam int NS = 3, DBS = 2;

   typedef struct {int e; int p; bit f;} res_t;

   logic clk = 1'b0, rst = 1'b0, tick = 1'b0;
   logic pbl = 1'b0, pbr = 1'b0, restart = 1'b0;
   logic [N-1:0] led;
   logic [3:0]   pos;
   logic         cue, fs, win_l, win_r;
   logic pbl_s = 1'b0, pbr_s = 1'b0, restart_s = 1'b0;
   logic [NS-1:0] led_s;
   logic [1:0]    pos_s;
   logic          cue_s, fs_s, wl_s, wr_s;

   int   ecnt;
   int   n_chk = 0, n_fail = 0;
   bit   mon_en = 1'b0;
   int   mpos = C;
   int   cue_q[$];
   int   rs_q[$];
   res_t res_q[$];
   res_t win_q[$];
   res_t mx;
   logic cue_p = 1'b0, wl_p = 1'b0, wr_p = 1'b0;

   tow_arena u_dut (
      .clk(clk), .rst(rst), .tick(tick), .pbl(pbl), .pbr(pbr), .restart(restart),
      .led(led), .pos(pos), .cue(cue), .false_start(fs), .win_l(win_l), .win_r(win_r)
   );

   tow_arena #(.NUM_LEDS(NS), .DELAY_BITS(DBS)) u_small (
      .clk(clk), .rst(rst), .tick(tick), .pbl(pbl_s), .pbr(pbr_s), .restart(restart_s),
      .led(led_s), .pos(pos_s), .cue(cue_s), .false_start(fs_s), .win_l(wl_s), .win_r(wr_s)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) ecnt <= 0;
      else      ecnt <= ecnt + 1;
   end

   always @(negedge clk) tick = ((ecnt + 1) % TP == 0);

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, ecnt);
      end
   endtask

   function automatic logic [15:0] lfsr_at(input int n);
      logic [15:0] l;
      l = 16'hACE1;
      for (int i = 0; i < n; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      return l;
   endfunction

   function automatic int nth_tick(input int e, input int n);
      return (e / TP + 1) * TP + (n - 1) * TP;
   endfunction

   function automatic int arm_dly(input int e, input int db);
      return DMIN + int'(lfsr_at(e - 1) & 16'((1 << db) - 1));
   endfunction

   function automatic res_t mk(input int e, input int p, input bit f);
      res_t x;
      x.e = e; x.p = p; x.f = f;
      return x;
   endfunction

   task automatic wait_edge(input int n);
      if (ecnt > n) chk("schedule_late", ecnt, n);
      while (ecnt < n) @(negedge clk);
   endtask

   // Raw level first sampled at edge e-3, so the press acts at edge e.
   task automatic press(input bit l, input bit r, input int e, input bit sm);
      wait_edge(e - 4);
      if (sm) begin pbl_s = l; pbr_s = r; end
      else    begin pbl = l;   pbr = r;   end
      wait_edge(e - 2);
      pbl = 1'b0; pbr = 1'b0; pbl_s = 1'b0; pbr_s = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) mpos = C;
      if (rst && mon_en) begin
         if (cue && !cue_p) begin
            if (cue_q.size() == 0) chk("unexpected_cue", 1, 0);
            else chk("cue_edge", ecnt, cue_q.pop_front());
         end
         if (fs || (cue_p && !cue)) begin
            if (res_q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
               mx = res_q.pop_front();
               chk("result_edge", ecnt, mx.e);
               chk("result_fs", int'(fs), int'(mx.f));
               mpos = mx.p;
            end
         end
         if ((win_l && !wl_p) || (win_r && !wr_p)) begin
            if (win_q.size() == 0) chk("unexpected_win", 1, 0);
            else begin
               mx = win_q.pop_front();
               chk("win_edge", ecnt, mx.e);
               chk("win_r", int'(win_r), int'(mx.f));
               chk("win_l", int'(win_l), int'(!mx.f));
            end
         end
         if ((wl_p || wr_p) && !win_l && !win_r) begin
            if (rs_q.size() == 0) chk("unexpected_clear", 1, 0);
            else begin
               chk("restart_edge", ecnt, rs_q.pop_front());
               mpos = C;
            end
         end
         chk("pos_track", int'(pos), mpos);
         if (!win_l && !win_r) chk("led_onehot", int'(led), 1 << mpos);
      end
      cue_p = cue; wl_p = win_l; wr_p = win_r;
   end

   initial begin
      #600000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion (edge %0d)", ecnt);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      int e0, dly, cue_e, E, Es, R, r, side, m_pos, meas;
      bit bl, br;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      mon_en = 1'b1;

      // First round after reset uses DELAY_MIN exactly; abandon it mid-CUE.
      cue_q.push_back(nth_tick(0, DMIN));
      wait_edge(nth_tick(0, DMIN) + 2);
      chk("pre_reset_cue", int'(cue), 1);
      #2 rst = 1'b0;
      #1;
      chk("rst_led", int'(led), 1 << C);
      chk("rst_pos", int'(pos), C);
      chk("rst_cue", int'(cue), 0);
      chk("rst_fs", int'(fs), 0);
      chk("rst_win", int'({win_l, win_r}), 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;

      m_pos = C; e0 = 0; dly = DMIN;
      for (int rd = 0; rd < 36; rd++) begin
         cue_e = nth_tick(e0, dly);
         r = (rd < 4) ? 9 : $urandom_range(0, 9);
         if (r <= 1) begin
            E = $urandom_range(e0 + 5, cue_e);
            side = $urandom_range(0, 1);
            m_pos += side ? -1 : 1;
            res_q.push_back(mk(E, m_pos, 1'b1));
            press(side == 0, side == 1, E, 1'b0);
         end else if (r == 2) begin
            E = $urandom_range(e0 + 5, cue_e);
            press(1'b1, 1'b1, E, 1'b0);
            e0 = E;
            dly = arm_dly(E, DB);
            wait_edge(e0);
            continue;
         end else begin
            cue_q.push_back(cue_e);
            wait_edge(e0 + 1);
            restart = 1'b1;
            @(negedge clk);
            restart = 1'b0;
            E = cue_e + 1 + $urandom_range(0, 20);
            side = (rd < 4) ? 1 : $urandom_range(0, 2);
            if (side == 1) m_pos++;
            else if (side == 0) m_pos--;
            res_q.push_back(mk(E, m_pos, 1'b0));
            press(side != 1, side != 0, E, 1'b0);
         end
         Es = nth_tick(E, HOLD);
         if ($urandom_range(0, 1) == 1) begin
            bl = 1'($urandom_range(0, 1));
            br = 1'($urandom_range(0, 1));
            if (!bl && !br) bl = 1'b1;
            press(bl, br, $urandom_range(E + 5, Es - 1), 1'b0);
         end
         if (m_pos == N - 1 || m_pos == 0) begin
            win_q.push_back(mk(Es, m_pos, m_pos == N - 1));
            wait_edge(Es);
            chk("blink_lit", int'(led), 1 << m_pos);
            for (int k = 1; k < 5; k++) begin
               wait_edge(nth_tick(ecnt, 1));
               chk("blink", int'(led), (k % 2 == 0) ? (1 << m_pos) : 0);
            end
            press(1'b1, 1'b0, ecnt + 5, 1'b0);
            R = ecnt + 2;
            rs_q.push_back(R);
            wait_edge(R - 1);
            restart = 1'b1;
            @(negedge clk);
            restart = 1'b0;
            m_pos = C; e0 = R; dly = arm_dly(R, DB);
         end else begin
            e0 = Es;
            dly = arm_dly(Es, DB);
         end
         wait_edge(e0);
      end
      @(negedge clk); @(negedge clk);
      chk("queues_drained", cue_q.size() + res_q.size() + win_q.size() + rs_q.size(), 0);

      // Three-lamp instance: one right win ends each match.
      mon_en = 1'b0;
      rst = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      e0 = 0; dly = DMIN;
      for (int i = 0; i < 6; i++) begin
         cue_e = nth_tick(e0, dly);
         while (!cue_s && ecnt < cue_e + 10) @(negedge clk);
         chk("s_cue_edge", ecnt, cue_e);
         meas = ecnt / TP - e0 / TP;
         chk("s_delay_in_range", int'(meas >= 16 && meas <= 19), 1);
         chk("s_pos_centre", int'(pos_s), 1);
         E = ecnt + 4;
         press(1'b0, 1'b1, E, 1'b1);
         wait_edge(E);
         chk("s_pos_end", int'(pos_s), 2);
         chk("s_cue_low", int'(cue_s), 0);
         Es = nth_tick(E, HOLD);
         wait_edge(Es - 1);
         chk("s_win_early", int'(wr_s), 0);
         wait_edge(Es);
         chk("s_win_r", int'(wr_s), 1);
         chk("s_led_lit", int'(led_s), 4);
         R = Es + 2;
         wait_edge(R - 1);
         restart_s = 1'b1;
         @(negedge clk);
         restart_s = 1'b0;
         chk("s_restart_pos", int'(pos_s), 1);
         chk("s_restart_win", int'({wl_s, wr_s}), 0);
         e0 = R;
         dly = arm_dly(R, DBS);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
